sync_up_counter: RTL and testbench
==================================

// Module: sync_up_counter
// PURPOSE
//  Synchronous, loadable, up-counting companion to the team's sync down counter.
//  Counts 0..MAX_VAL on enabled cycles, then wraps to 0 or saturates at MAX_VAL.
//  Provides a terminal-count carry so counters can be cascaded, a one-cycle wrap pulse
//  and a sticky overflow flag.
//  Used as an event/tick counter in the day-by-day RTL test designs.
// PARAMETERS
//  WIDTH     4    counter width in bits (>=1)
//  MAX_VAL   15   terminal count, 0 < MAX_VAL <= 2**WIDTH-1
//  SATURATE  0    0 = wrap MAX_VAL->0; 1 = hold at MAX_VAL
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  en        in   1      count enable; increment by 1 on this cycle
//  clr       in   1      synchronous clear of count and ovf
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value loaded when load=1
//  counter   out  WIDTH  current count (registered)
//  tc        out  1      terminal count / carry-out, combinational
//  wrap      out  1      registered one-cycle pulse after a wrap
//  ovf       out  1      sticky overflow flag, registered
// BEHAVIOUR
//  - Only rising edges of clk update state; no level-sensitive or async paths.
//  - Reset (rst=1 at edge): counter=0, wrap=0, ovf=0. rst overrides all other inputs.
//  - Per-edge priority: rst > clr > load > en > hold.
//  - clr: counter<=0, ovf<=0, wrap<=0.
//  - load: counter<=min(load_val, MAX_VAL); wrap<=0; ovf unchanged.
//    No increment on that cycle, even when en=1.
//  - en with counter<MAX_VAL: counter<=counter+1; wrap<=0.
//  - en with counter==MAX_VAL:
//    - SATURATE=0: counter<=0, wrap<=1, ovf<=1.
//    - SATURATE=1: counter holds MAX_VAL, wrap<=0, ovf<=1.
//  - en=0 and no other command: counter and ovf hold; wrap<=0.
//    wrap is never high for 2 consecutive cycles unless en stays high and MAX_VAL==0.
//    MAX_VAL==0 is illegal.
//  - tc = en & (counter==MAX_VAL) & ~rst & ~clr & ~load (combinational; carry into next stage).
//  - Arithmetic is unsigned modulo 2**WIDTH. The compare against MAX_VAL is done before
//    the increment, so the internal width never overflows.
//  - Latency: an input at edge N is visible on counter/wrap/ovf after edge N; tc is same-cycle.
//  - Mid-operation reset or clear returns to 0 on the next edge regardless of en/load.
// TESTING
//  1. rst=1 for 2 cycles, then en=0 for 3 cycles
//     -> counter=0, wrap=0, ovf=0, tc=0 throughout.
//  2. Defaults; en=1 for 16 cycles from 0
//     -> counter steps 1..15 then 0; tc=1 only while counter=15;
//        wrap=1 exactly on the cycle counter=0 after the wrap; ovf=1 from then on.
//  3. SATURATE=1; en=1 for 20 cycles
//     -> counter sticks at 15; wrap never asserts; ovf=1 after the first enable at 15.
//  4. load=1, load_val=9, en=1 -> counter=9 (no increment); next en -> 10.
//     With MAX_VAL=12: load_val=14 -> counter=12.
//  5. counter=7, then assert clr and load together (load_val=3) -> counter=0, ovf=0.
//     Then assert rst together with clr/load/en -> counter=0.
//  6. Cascade two instances (tc of the low counter drives en of the high counter);
//     en=1 for 40 cycles -> {hi,lo} = 40 decimal (hi=2, lo=8).

Source files
------------

// File: rtl/sync_up_counter_if.sv
// Command/status bundle for sync_up_counter: the master drives count commands,
// the slave (the counter) returns count, carry, wrap pulse and overflow.
interface sync_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, clr, load, load_val,
    input  counter, tc, wrap, ovf
  );

  modport slave (
    input  en, clr, load, load_val,
    output counter, tc, wrap, ovf
  );
endinterface

// File: rtl/sync_up_counter.sv
// Loadable up counter 0..MAX_VAL with wrap or saturate, cascadable carry (tc),
// one-cycle wrap pulse and sticky overflow. Fully synchronous.
module sync_up_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 15,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  sync_up_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_counter;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_at_max;
  logic [WIDTH-1:0] w_load_clip;

  // Comparing before incrementing keeps the count inside WIDTH bits.
  assign w_at_max    = (r_counter == L_MAX);
  assign w_load_clip = (bus.load_val > L_MAX) ? L_MAX : bus.load_val;

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_counter <= '0;
      r_wrap    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (bus.clr) begin
      r_counter <= '0;
      r_wrap    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (bus.load) begin
      r_counter <= w_load_clip;
      r_wrap    <= 1'b0;
    end else if (bus.en) begin
      if (!w_at_max) begin
        r_counter <= r_counter + WIDTH'(1);
        r_wrap    <= 1'b0;
      end else if (SATURATE) begin
        r_wrap    <= 1'b0;
        r_ovf     <= 1'b1;
      end else begin
        r_counter <= '0;
        r_wrap    <= 1'b1;
        r_ovf     <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Same-cycle carry into a following stage; suppressed by any higher-priority command.
  assign bus.tc      = bus.en & w_at_max & ~rst & ~bus.clr & ~bus.load;
  assign bus.counter = r_counter;
  assign bus.wrap    = r_wrap;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_sync_up_counter.sv
// Self-checking bench: three single counters (wrap, saturate, MAX_VAL=12) and an
// 8-bit cascade, all compared each cycle against a behavioural model.
module tb_sync_up_counter;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;

  int checks   = 0;
  int failures = 0;

  sync_up_counter_if #(.WIDTH(W)) if_a ();
  sync_up_counter_if #(.WIDTH(W)) if_b ();
  sync_up_counter_if #(.WIDTH(W)) if_c ();
  sync_up_counter_if #(.WIDTH(W)) if_lo ();
  sync_up_counter_if #(.WIDTH(W)) if_hi ();

  assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.load = load;  assign if_a.load_val = load_val;
  assign if_b.en = en;  assign if_b.clr = clr;  assign if_b.load = load;  assign if_b.load_val = load_val;
  assign if_c.en = en;  assign if_c.clr = clr;  assign if_c.load = load;  assign if_c.load_val = load_val;

  assign if_lo.en = en;        assign if_lo.clr = clr;  assign if_lo.load = 1'b0;  assign if_lo.load_val = '0;
  assign if_hi.en = if_lo.tc;  assign if_hi.clr = clr;  assign if_hi.load = 1'b0;  assign if_hi.load_val = '0;

  sync_up_counter #(.WIDTH(W), .MAX_VAL(15), .SATURATE(1'b0)) u_a  (.clk(clk), .rst(rst), .bus(if_a));
  sync_up_counter #(.WIDTH(W), .MAX_VAL(15), .SATURATE(1'b1)) u_b  (.clk(clk), .rst(rst), .bus(if_b));
  sync_up_counter #(.WIDTH(W), .MAX_VAL(12), .SATURATE(1'b0)) u_c  (.clk(clk), .rst(rst), .bus(if_c));
  sync_up_counter #(.WIDTH(W), .MAX_VAL(15), .SATURATE(1'b0)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));
  sync_up_counter #(.WIDTH(W), .MAX_VAL(15), .SATURATE(1'b0)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));

  logic [W-1:0] cnt_obs [3];
  logic         tc_obs  [3];
  logic         wrap_obs[3];
  logic         ovf_obs [3];

  assign cnt_obs[0] = if_a.counter;  assign tc_obs[0] = if_a.tc;  assign wrap_obs[0] = if_a.wrap;  assign ovf_obs[0] = if_a.ovf;
  assign cnt_obs[1] = if_b.counter;  assign tc_obs[1] = if_b.tc;  assign wrap_obs[1] = if_b.wrap;  assign ovf_obs[1] = if_b.ovf;
  assign cnt_obs[2] = if_c.counter;  assign tc_obs[2] = if_c.tc;  assign wrap_obs[2] = if_c.wrap;  assign ovf_obs[2] = if_c.ovf;

  // Reference model: plain integer count plus wrap/ovf flags per configuration.
  typedef struct {
    int cnt;
    bit wrap;
    bit ovf;
  } mdl_t;

  mdl_t m[3];
  int   casc;   // cascade value as one 8-bit integer

  function automatic int max_of(int i);
    return (i == 2) ? 12 : 15;
  endfunction

  function automatic bit sat_of(int i);
    return (i == 1);
  endfunction

  function automatic mdl_t step_model(mdl_t s, int maxv, bit sat,
                                      bit r, bit c, bit l, bit e, int lv);
    mdl_t n = s;
    n.wrap = 1'b0;
    if (r || c) begin
      n.cnt = 0;
      n.ovf = 1'b0;
    end else if (l) begin
      n.cnt = (lv < maxv) ? lv : maxv;
    end else if (e) begin
      if (s.cnt < maxv) begin
        n.cnt = s.cnt + 1;
      end else begin
        n.ovf = 1'b1;
        if (!sat) begin
          n.cnt  = 0;
          n.wrap = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check combinational tc before the edge, registered outputs after it.
  task automatic cycle();
    bit cmd_free;
    @(negedge clk);
    cmd_free = en && !rst && !clr && !load;
    for (int i = 0; i < 3; i++)
      check($sformatf("tc[%0d]", i), 32'(tc_obs[i]), 32'(cmd_free && m[i].cnt == max_of(i)));
    check("tc_lo", 32'(if_lo.tc), 32'(en && !rst && !clr && (casc % 16) == 15));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      m[i] = step_model(m[i], max_of(i), sat_of(i), rst, clr, load, en, int'(load_val));
    casc = (rst || clr) ? 0 : (en ? (casc + 1) % 256 : casc);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cnt[%0d]", i),  32'(cnt_obs[i]),  32'(m[i].cnt));
      check($sformatf("wrap[%0d]", i), 32'(wrap_obs[i]), 32'(m[i].wrap));
      check($sformatf("ovf[%0d]", i),  32'(ovf_obs[i]),  32'(m[i].ovf));
    end
    check("casc_lo", 32'(if_lo.counter), 32'(casc % 16));
    check("casc_hi", 32'(if_hi.counter), 32'(casc / 16));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m[i] = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
    casc     = 0;
    rst      = 1'b1;
    en       = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;

    // Reset, then idle.
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check("rst_cnt",  32'(if_a.counter), 32'd0);
    check("rst_ovf",  32'(if_a.ovf),     32'd0);
    check("rst_wrap", 32'(if_a.wrap),    32'd0);

    // Count 0..15 and wrap on the wrap-mode counter.
    en = 1'b1;
    repeat (15) cycle();
    check("a_at_15", 32'(if_a.counter), 32'd15);
    cycle();
    check("a_wrapped", 32'(if_a.counter), 32'd0);
    check("a_wrap_pulse", 32'(if_a.wrap), 32'd1);
    check("a_ovf_set", 32'(if_a.ovf), 32'd1);

    // Keep counting: the saturating counter sticks at 15.
    repeat (20) cycle();
    check("b_sat_hold", 32'(if_b.counter), 32'd15);
    check("b_no_wrap",  32'(if_b.wrap),    32'd0);
    check("b_ovf",      32'(if_b.ovf),     32'd1);

    // Load wins over en; next enable increments.
    load = 1'b1;  load_val = 4'd9;
    cycle();
    check("load9", 32'(if_a.counter), 32'd9);
    load = 1'b0;
    cycle();
    check("load9_inc", 32'(if_a.counter), 32'd10);
    load = 1'b1;  load_val = 4'd14;  en = 1'b0;
    cycle();
    check("c_load_clip", 32'(if_c.counter), 32'd12);
    check("a_load14",    32'(if_a.counter), 32'd14);

    // Clear beats load; reset beats everything.
    load_val = 4'd7;
    cycle();
    clr = 1'b1;  load = 1'b1;  load_val = 4'd3;
    cycle();
    check("clr_cnt", 32'(if_a.counter), 32'd0);
    check("clr_ovf", 32'(if_a.ovf),     32'd0);
    clr = 1'b0;  load = 1'b0;  en = 1'b1;
    repeat (5) cycle();
    rst = 1'b1;  clr = 1'b1;  load = 1'b1;  load_val = 4'd5;
    cycle();
    check("rst_all", 32'(if_a.counter), 32'd0);
    rst = 1'b0;  clr = 1'b0;  load = 1'b0;

    // Cascade: 40 enables from zero gives hi=2, lo=8.
    repeat (40) cycle();
    check("casc40_hi", 32'(if_hi.counter), 32'd2);
    check("casc40_lo", 32'(if_lo.counter), 32'd8);

    // Randomised commands against the model.
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 63) == 0);
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = W'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
